// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA/VESA raster timing generator in the pixel clock domain
module vga_timing_gen #(
    parameter int CW        = 11,
    parameter int H_VISIBLE = 1280,
    parameter int H_FP      = 48,
    parameter int H_PULSE   = 112,
    parameter int H_BP      = 248,
    parameter int V_VISIBLE = 1024,
    parameter int V_FP      = 1,
    parameter int V_PULSE   = 3,
    parameter int V_BP      = 38,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int FW        = 8
) (
    input  logic          px_clk,
    input  logic          clr_n,
    input  logic          en,
    input  logic [CW-1:0] irq_line,
    output logic [CW-1:0] hc,
    output logic [CW-1:0] vc,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          line_irq,
    output logic [FW-1:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_PULSE + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_PULSE + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Boundaries are one bit wider so a sync ending exactly at 2^CW still decodes.
    localparam logic [CW:0] H_BLANK_START = (CW+1)'(H_VISIBLE);
    localparam logic [CW:0] H_SYNC_START  = (CW+1)'(H_VISIBLE + H_FP);
    localparam logic [CW:0] H_SYNC_END    = (CW+1)'(H_VISIBLE + H_FP + H_PULSE);
    localparam logic [CW:0] V_BLANK_START = (CW+1)'(V_VISIBLE);
    localparam logic [CW:0] V_SYNC_START  = (CW+1)'(V_VISIBLE + V_FP);
    localparam logic [CW:0] V_SYNC_END    = (CW+1)'(V_VISIBLE + V_FP + V_PULSE);

    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;
    logic [FW-1:0] r_frame_cnt;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_hblank;
    logic          r_vblank;
    logic          r_active;
    logic          r_line_start;
    logic          r_frame_start;
    logic          r_line_irq;

    logic          w_h_last;
    logic          w_v_last;
    logic [CW-1:0] w_hc_nxt;
    logic [CW-1:0] w_vc_nxt;
    logic [CW:0]   w_hc_ext;
    logic [CW:0]   w_vc_ext;
    logic          w_hblank_nxt;
    logic          w_vblank_nxt;
    logic          w_hsync_on_nxt;
    logic          w_vsync_on_nxt;

    // Next counter position and the level outputs decoded from it, so levels line up with hc/vc.
    always_comb begin
        w_h_last       = (r_hc == H_LAST);
        w_v_last       = (r_vc == V_LAST);
        w_hc_nxt       = w_h_last ? '0 : r_hc + CW'(1);
        w_vc_nxt       = r_vc;
        if (w_h_last) begin
            w_vc_nxt   = w_v_last ? '0 : r_vc + CW'(1);
        end
        w_hc_ext       = {1'b0, w_hc_nxt};
        w_vc_ext       = {1'b0, w_vc_nxt};
        w_hblank_nxt   = (w_hc_ext >= H_BLANK_START);
        w_vblank_nxt   = (w_vc_ext >= V_BLANK_START);
        w_hsync_on_nxt = (w_hc_ext >= H_SYNC_START) && (w_hc_ext < H_SYNC_END);
        w_vsync_on_nxt = (w_vc_ext >= V_SYNC_START) && (w_vc_ext < V_SYNC_END);
    end

    // Raster state: advance on en, freeze levels and silence strobes while stalled.
    always_ff @(posedge px_clk) begin
        if (!clr_n) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_frame_cnt   <= '0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_hblank      <= 1'b0;
            r_vblank      <= 1'b0;
            r_active      <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_irq    <= 1'b0;
        end else if (en) begin
            r_hc          <= w_hc_nxt;
            r_vc          <= w_vc_nxt;
            if (w_h_last && w_v_last) begin
                r_frame_cnt <= r_frame_cnt + FW'(1);
            end
            r_hsync       <= w_hsync_on_nxt ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_vsync_on_nxt ? VSYNC_POL : ~VSYNC_POL;
            r_hblank      <= w_hblank_nxt;
            r_vblank      <= w_vblank_nxt;
            r_active      <= ~w_hblank_nxt & ~w_vblank_nxt;
            r_line_start  <= w_h_last;
            r_frame_start <= w_h_last & w_v_last;
            // vc never exceeds V_TOTAL-1, so an out-of-range irq_line can never match.
            r_line_irq    <= w_h_last && (w_vc_nxt == irq_line);
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_irq    <= 1'b0;
        end
    end

    assign hc          = r_hc;
    assign vc          = r_vc;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign active      = r_active;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign line_irq    = r_line_irq;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a 16x8 raster
module tb_vga_timing_gen;

    logic       px_clk;
    logic       clr_n;
    logic       en;
    logic [4:0] irq_line;
    logic [4:0] hc;
    logic [4:0] vc;
    logic       hsync;
    logic       vsync;
    logic       hblank;
    logic       vblank;
    logic       active;
    logic       line_start;
    logic       frame_start;
    logic       line_irq;
    logic [1:0] frame_cnt;

    vga_timing_gen #(
        .CW(5), .H_VISIBLE(8), .H_FP(2), .H_PULSE(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_PULSE(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .FW(2)
    ) dut (
        .px_clk(px_clk), .clr_n(clr_n), .en(en), .irq_line(irq_line),
        .hc(hc), .vc(vc), .hsync(hsync), .vsync(vsync),
        .hblank(hblank), .vblank(vblank), .active(active),
        .line_start(line_start), .frame_start(frame_start), .line_irq(line_irq),
        .frame_cnt(frame_cnt)
    );

    initial px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    typedef struct {
        int hc; int vc; int hs; int vs; int hb; int vb; int act;
        int ls; int fs; int li; int fc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   m_pos    = 0;   // enabled advances since the last reset

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, push the model's expectation, then pop and compare after the edge.
    task automatic drive(input logic t_en, input logic t_clr, input logic [4:0] t_irq);
        exp_t e;
        int   h;
        int   v;
        en       = t_en;
        clr_n    = t_clr;
        irq_line = t_irq;
        e.ls = 0; e.fs = 0; e.li = 0;
        if (!t_clr) begin
            m_pos = 0;
        end else if (t_en) begin
            m_pos++;
            e.ls = (m_pos % 16 == 0) ? 1 : 0;
            e.fs = (m_pos % 128 == 0) ? 1 : 0;
            e.li = (e.ls == 1 && ((m_pos / 16) % 8) == int'(t_irq)) ? 1 : 0;
        end
        h     = m_pos % 16;
        v     = (m_pos / 16) % 8;
        e.hc  = h;
        e.vc  = v;
        e.fc  = (m_pos / 128) % 4;
        e.hs  = (h >= 10 && h <= 12) ? 0 : 1;
        e.vs  = (v >= 5 && v <= 6) ? 1 : 0;
        e.hb  = (h >= 8) ? 1 : 0;
        e.vb  = (v >= 4) ? 1 : 0;
        e.act = (h < 8 && v < 4) ? 1 : 0;
        sb_q.push_back(e);
        @(posedge px_clk);
        #1;
        e = sb_q.pop_front();
        check_eq("hc", 32'(hc), e.hc);
        check_eq("vc", 32'(vc), e.vc);
        check_eq("hsync", 32'(hsync), e.hs);
        check_eq("vsync", 32'(vsync), e.vs);
        check_eq("hblank", 32'(hblank), e.hb);
        check_eq("vblank", 32'(vblank), e.vb);
        check_eq("active", 32'(active), e.act);
        check_eq("line_start", 32'(line_start), e.ls);
        check_eq("frame_start", 32'(frame_start), e.fs);
        check_eq("line_irq", 32'(line_irq), e.li);
        check_eq("frame_cnt", 32'(frame_cnt), e.fc);
    endtask

    initial begin
        int first_fs;
        int fs_cnt;
        int ls_cnt;
        int irq_cnt;
        int coinc;
        int cyc;
        en       = 1'b0;
        clr_n    = 1'b0;
        irq_line = 5'd3;

        // Reset with en high: en must be ignored.
        drive(1'b1, 1'b0, 5'd3);
        drive(1'b1, 1'b0, 5'd3);

        // Four free-running frames with irq_line=3.
        first_fs = -1; fs_cnt = 0; ls_cnt = 0; irq_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            drive(1'b1, 1'b1, 5'd3);
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = m_pos;
            end
            if (line_start === 1'b1) ls_cnt++;
            if (line_irq === 1'b1) irq_cnt++;
        end
        check_eq("first_frame_start_cycle", first_fs, 128);
        check_eq("frame_start_count", fs_cnt, 4);
        check_eq("line_start_count", ls_cnt, 32);
        check_eq("irq3_count", irq_cnt, 4);
        check_eq("frame_cnt_wrapped", 32'(frame_cnt), 0);

        // irq_line=0: the interrupt coincides with frame_start.
        irq_cnt = 0; coinc = 0;
        for (int i = 0; i < 128; i++) begin
            drive(1'b1, 1'b1, 5'd0);
            if (line_irq === 1'b1) begin
                irq_cnt++;
                if (frame_start === 1'b1) coinc++;
            end
        end
        check_eq("irq0_count", irq_cnt, 1);
        check_eq("irq0_with_frame_start", coinc, 1);

        // irq_line beyond the frame never fires.
        irq_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            drive(1'b1, 1'b1, 5'd9);
            if (line_irq === 1'b1) irq_cnt++;
        end
        check_eq("irq9_count", irq_cnt, 0);

        // Stall five cycles sitting at hc=0, vc=2.
        drive(1'b1, 1'b0, 5'd3);
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b1, 5'd3);
        check_eq("stall_at_hc", 32'(hc), 0);
        check_eq("stall_at_vc", 32'(vc), 2);
        ls_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 5'd3);
            if (line_start === 1'b1) ls_cnt++;
        end
        drive(1'b1, 1'b1, 5'd3);
        if (line_start === 1'b1) ls_cnt++;
        check_eq("no_refire_after_stall", ls_cnt, 0);
        cyc = 32 + 5 + 1;
        for (int i = 0; i < 200; i++) begin
            if (frame_start === 1'b1) break;
            drive(1'b1, 1'b1, 5'd3);
            cyc++;
        end
        check_eq("stalled_frame_length", cyc, 133);

        // Reset mid-frame at hc=11, vc=5 with en high.
        for (int i = 0; i < 91; i++) drive(1'b1, 1'b1, 5'd3);
        check_eq("pre_reset_hc", 32'(hc), 11);
        check_eq("pre_reset_vc", 32'(vc), 5);
        drive(1'b1, 1'b0, 5'd3);
        check_eq("rst_hc", 32'(hc), 0);
        check_eq("rst_vc", 32'(vc), 0);
        check_eq("rst_hsync", 32'(hsync), 1);
        check_eq("rst_vsync", 32'(vsync), 0);
        check_eq("rst_active", 32'(active), 1);
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, 5'd3);

        // Random enables, irq lines and occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
                  5'($urandom_range(0, 9)));
        end

        check_eq("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/VESA timing generator running entirely in the pixel clock domain. No PLL inside; the pixel clock is supplied from outside.
- Produces the following, all registered and mutually aligned:
  - horizontal/vertical counters
  - syncs with configurable polarity
  - blanking and active-video flags
  - line/frame start strobes
  - programmable line interrupt
  - frame counter
- Adds a stall enable so video pipelines and the character renderer can freeze timing without glitches.

Parameters:
- CW, 11, counter width for hc, vc, irq_line. Both totals must be ≤ 2^CW.
- H_VISIBLE, 1280, visible pixels per line
- H_FP, 48, horizontal front porch
- H_PULSE, 112, hsync pulse length
- H_BP, 248, horizontal back porch
- V_VISIBLE, 1024, visible lines per frame
- V_FP, 1, vertical front porch
- V_PULSE, 3, vsync pulse length
- V_BP, 38, vertical back porch
- HSYNC_POL, 1, active level of hsync
- VSYNC_POL, 1, active level of vsync
- FW, 8, frame counter width
- Derived: H_TOTAL = sum of H_* (1688); V_TOTAL = sum of V_* (1066).

Ports:
- px_clk  in  1  pixel clock; all logic on rising edge
- clr_n  in  1  synchronous active-low reset
- en  in  1  advance enable; low = hold timing
- irq_line  in  CW  line number (vc) at whose start line_irq fires
- hc  out  CW  horizontal position, 0..H_TOTAL-1
- vc  out  CW  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity HSYNC_POL
- vsync  out  1  vertical sync, polarity VSYNC_POL
- hblank  out  1  hc ≥ H_VISIBLE
- vblank  out  1  vc ≥ V_VISIBLE
- active  out  1  ~hblank & ~vblank
- line_start  out  1  one-cycle strobe on entering hc=0
- frame_start  out  1  one-cycle strobe on entering hc=0, vc=0
- line_irq  out  1  one-cycle strobe on entering hc=0 with vc=irq_line
- frame_cnt  out  FW  completed-frame count, wraps modulo 2^FW

Behaviour:
- Line layout, hc order: visible [0, H_VISIBLE), front porch, sync [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_PULSE), back porch. Vertical layout is identical on vc.
- All outputs are registers. hsync, vsync, hblank, vblank and active always describe the current hc/vc values in the same cycle, with zero skew. Implement by decoding next-state counter values.
- Counting, when en=1:
  - hc increments each cycle.
  - When hc=H_TOTAL-1, hc goes to 0 and vc increments.
  - When vc=V_TOTAL-1 at that point, vc goes to 0 and frame_cnt increments.
  - Counters never reach H_TOTAL or V_TOTAL.
- Stall, when en=0:
  - hc, vc, frame_cnt, hsync, vsync, blanks and active hold their values.
  - line_start, frame_start and line_irq are 0.
  - Strobes fire only in the cycle a position is entered. A stall while sitting at hc=0 does not re-fire them.
- Strobes:
  - line_start=1 in the first cycle hc=0 after a wrap.
  - frame_start additionally requires vc=0.
  - line_irq requires the entered vc to equal irq_line. irq_line is compared against the next vc value; a change takes effect on the next line entry.
  - If irq_line ≥ V_TOTAL, line_irq never fires.
  - All three may be high in the same cycle.
- Reset, when clr_n=0 at a px_clk edge:
  - hc=0, vc=0, frame_cnt=0
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL
  - hblank=0, vblank=0, active=1
  - line_start=0, frame_start=0, line_irq=0
- Reset has priority over en. Reset asserted mid-frame forces the above on the next edge. The first frame after reset emits no frame_start at position (0,0); the first frame_start comes at the first wrap.
- en is ignored during reset. The first advance is the first edge with clr_n=1 and en=1.
- Frame length is exactly H_TOTAL*V_TOTAL enabled cycles.
- frame_cnt wraps from 2^FW-1 to 0 without a flag.

Test Plan:
Small config for all scenarios: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), HSYNC_POL=0, VSYNC_POL=1, CW=5, FW=2.
1. Reset then en=1 continuously:
   - hc counts 0..15 and wraps.
   - hblank=1 exactly for hc 8..15.
   - hsync=0 exactly for hc 10..12.
   - line_start pulses at cycles 16, 32, …
   - First frame_start at cycle 128, when frame_cnt becomes 1.
2. Vertical:
   - vblank=1 for vc 4..7.
   - vsync=1 for vc 5..6, transitions coincident with hc=0.
   - active=1 only when hc<8 and vc<4.
   - After 4 frames frame_cnt returns to 0.
3. irq_line=3:
   - line_irq pulses once per frame when entering (hc=0, vc=3).
   - irq_line=0 → line_irq coincides with frame_start.
   - irq_line=9 → never fires.
4. Drop en for 5 cycles at hc=0, vc=2:
   - All counters and levels frozen, strobes 0.
   - line_start does not re-fire on resume.
   - The frame ends 5 cycles later than unstalled.
5. Assert clr_n=0 with en=1 at hc=11, vc=5:
   - Next edge gives hc=0, vc=0, hsync=1, vsync=0, active=1, strobes 0.
   - Counting restarts on release.
6. Default parameters, one full frame:
   - 1688*1066 = 1,799,408 cycles between frame_start pulses.
   - hsync high for 112 cycles per line.
   - vsync high for 3 lines.
